// File: rtl/eth_fifo_pipe_ctrl_if.sv
// Handshake and RAM-control bundle between eth_fifo_pipe_ctrl and its producer, consumer and RAM.
// master = the controller, slave = the environment (producer/consumer/RAM side).
interface eth_fifo_pipe_ctrl_if #(
  parameter int unsigned els_p             = 4,
  parameter int unsigned pipeline_output_p = 2,
  parameter int unsigned drop_cnt_width_p  = 16
);
  localparam int unsigned AW = $clog2(els_p);

  logic                         v_i;
  logic                         ready_o;
  logic                         w_v_o;
  logic [AW-1:0]                w_addr_o;
  logic                         r_v_o;
  logic [AW-1:0]                r_addr_o;
  logic                         output_ready_o;
  logic [pipeline_output_p-1:0] valid_pipe_reg_o;
  logic                         v_o;
  logic                         yumi_i;
  logic [drop_cnt_width_p-1:0]  drop_count_o;

  modport master (
    input  v_i, yumi_i,
    output ready_o, w_v_o, w_addr_o, r_v_o, r_addr_o, output_ready_o,
           valid_pipe_reg_o, v_o, drop_count_o
  );

  modport slave (
    output v_i, yumi_i,
    input  ready_o, w_v_o, w_addr_o, r_v_o, r_addr_o, output_ready_o,
           valid_pipe_reg_o, v_o, drop_count_o
  );
endinterface

// File: rtl/eth_fifo_pipe_ctrl.sv
// Pointer/occupancy/valid-pipe control for a pipelined 1R1W RAM FIFO; never touches data.
// Optional saturating drop counter enabled by defining ETH_FIFO_PIPE_CTRL_DROP_CNT_EN.
module eth_fifo_pipe_ctrl #(
  parameter int unsigned els_p             = 4,
  parameter int unsigned pipeline_output_p = 2,
  parameter int unsigned drop_cnt_width_p  = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  eth_fifo_pipe_ctrl_if.master  bus
);
  localparam int unsigned P  = pipeline_output_p;
  localparam int unsigned AW = $clog2(els_p);
  localparam int unsigned CW = $clog2(els_p + 1);
  localparam int unsigned DW = drop_cnt_width_p;

  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [P-1:0]  vld_q, vld_d;
  logic [P:1]    sh_c;
  logic          ready_c, w_v_c, r_v_c;

  // Write side depends only on occupancy, so yumi_i never reaches ready_o.
  assign ready_c = (count_q != CW'(els_p));
  assign w_v_c   = bus.v_i & ready_c;

  // Stage j may accept new contents when it is empty or the tail is being consumed.
  always_comb begin
    sh_c = {P{bus.yumi_i}};
    for (int j = 1; j < int'(P); j++) begin
      sh_c[j] = bus.yumi_i | ~vld_q[j];
    end
  end

  assign r_v_c   = (count_q != '0) & (~vld_q[0] | sh_c[1]);
  assign count_d = count_q + CW'(w_v_c) - CW'(r_v_c);

  // Moving an entry down clears its source stage so nothing is duplicated.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = r_v_c | (vld_q[0] & ~sh_c[1]);
    for (int j = 1; j < int'(P); j++) begin
      vld_d[j] = sh_c[j] ? vld_q[j-1] : (vld_q[j] & ~sh_c[j+1]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (w_v_c) wptr_q <= (wptr_q == AW'(els_p - 1)) ? '0 : wptr_q + AW'(1);
      if (r_v_c) rptr_q <= (rptr_q == AW'(els_p - 1)) ? '0 : rptr_q + AW'(1);
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ETH_FIFO_PIPE_CTRL_DROP_CNT_EN
  logic [DW-1:0] drop_q;

  // Counts refused write attempts, sticking at all-ones until reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop_q <= '0;
    end else if (bus.v_i && !ready_c && (drop_q != {DW{1'b1}})) begin
      drop_q <= drop_q + DW'(1);
    end
  end

  assign bus.drop_count_o = drop_q;
`else
  assign bus.drop_count_o = '0;
`endif

  assign bus.ready_o          = ready_c;
  assign bus.w_v_o            = w_v_c;
  assign bus.w_addr_o         = wptr_q;
  assign bus.r_v_o            = r_v_c;
  assign bus.r_addr_o         = rptr_q;
  assign bus.output_ready_o   = bus.yumi_i;
  assign bus.valid_pipe_reg_o = vld_q;
  assign bus.v_o              = vld_q[P-1];

`ifdef ASSERT_EN
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(bus.yumi_i && !vld_q[P-1]))
        else $error("eth_fifo_pipe_ctrl: yumi_i asserted while v_o is low");
    end
  end
`endif
endmodule

// File: tb/tb_eth_fifo_pipe_ctrl.sv
// Directed self-checking bench for eth_fifo_pipe_ctrl over three configurations.
module tb_eth_fifo_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef ETH_FIFO_PIPE_CTRL_DROP_CNT_EN
  localparam int unsigned A_DROP = 5;
  localparam int unsigned C_DROP = 3;
`else
  localparam int unsigned A_DROP = 0;
  localparam int unsigned C_DROP = 0;
`endif

  always #5 clk = ~clk;

  eth_fifo_pipe_ctrl_if #(.els_p(4), .pipeline_output_p(2), .drop_cnt_width_p(16)) a_if ();
  eth_fifo_pipe_ctrl_if #(.els_p(4), .pipeline_output_p(3), .drop_cnt_width_p(16)) b_if ();
  eth_fifo_pipe_ctrl_if #(.els_p(3), .pipeline_output_p(2), .drop_cnt_width_p(2))  c_if ();

  eth_fifo_pipe_ctrl #(.els_p(4), .pipeline_output_p(2), .drop_cnt_width_p(16)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .bus(a_if.master));
  eth_fifo_pipe_ctrl #(.els_p(4), .pipeline_output_p(3), .drop_cnt_width_p(16)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .bus(b_if.master));
  eth_fifo_pipe_ctrl #(.els_p(3), .pipeline_output_p(2), .drop_cnt_width_p(2)) u_c (
    .clk_i(clk), .reset_n_i(rst_n), .bus(c_if.master));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.v_i = 1'b1; a_if.yumi_i = 1'b0;
    b_if.v_i = 1'b0; b_if.yumi_i = 1'b0;
    c_if.v_i = 1'b0; c_if.yumi_i = 1'b0;

    // Outputs while held in reset
    #1;
    check("rst_ready",   32'(a_if.ready_o), 1);
    check("rst_w_v",     32'(a_if.w_v_o), 1);
    check("rst_r_v",     32'(a_if.r_v_o), 0);
    check("rst_v_o",     32'(a_if.v_o), 0);
    check("rst_vld",     32'(a_if.valid_pipe_reg_o), 0);
    check("rst_drop",    32'(a_if.drop_count_o), 0);
    check("rst_out_rdy", 32'(a_if.output_ready_o), 0);
    repeat (2) @(negedge clk);
    a_if.v_i = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_waddr", 32'(a_if.w_addr_o), 0);
    check("rst_raddr", 32'(a_if.r_addr_o), 0);

    // A: single write latency, P=2
    a_if.v_i = 1'b1;
    #1;
    check("a1_w_v", 32'(a_if.w_v_o), 1);
    check("a1_r_v_no_bypass", 32'(a_if.r_v_o), 0);
    @(negedge clk); a_if.v_i = 1'b0; #1;
    check("a2_r_v", 32'(a_if.r_v_o), 1);
    check("a2_raddr", 32'(a_if.r_addr_o), 0);
    check("a2_waddr", 32'(a_if.w_addr_o), 1);
    @(negedge clk); #1;
    check("a3_vld", 32'(a_if.valid_pipe_reg_o), 32'h1);
    check("a3_raddr", 32'(a_if.r_addr_o), 1);
    check("a3_v_o", 32'(a_if.v_o), 0);
    @(negedge clk); a_if.yumi_i = 1'b1; #1;
    check("a4_v_o", 32'(a_if.v_o), 1);
    check("a4_vld", 32'(a_if.valid_pipe_reg_o), 32'h2);
    check("a4_out_rdy", 32'(a_if.output_ready_o), 1);
    @(negedge clk); a_if.yumi_i = 1'b0; #1;
    check("a5_v_o", 32'(a_if.v_o), 0);
    check("a5_vld", 32'(a_if.valid_pipe_reg_o), 0);

    // A: fill until full, then 5 refused writes
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      a_if.v_i = (k <= 11);
      #1;
      check($sformatf("fill_ready_%0d", k), 32'(a_if.ready_o), 32'(k <= 6));
      check($sformatf("fill_r_v_%0d", k), 32'(a_if.r_v_o), 32'(k == 2 || k == 3));
      if (k <= 11) check($sformatf("fill_w_v_%0d", k), 32'(a_if.w_v_o), 32'(k <= 6));
    end
    check("a_drop", 32'(a_if.drop_count_o), A_DROP);
    check("a_full_vld", 32'(a_if.valid_pipe_reg_o), 32'h3);
    check("a_full_v_o", 32'(a_if.v_o), 1);

    // A: single yumi with full pipe issues exactly one read
    @(negedge clk); a_if.yumi_i = 1'b1; #1;
    check("pulse_r_v", 32'(a_if.r_v_o), 1);
    check("pulse_raddr", 32'(a_if.r_addr_o), 3);
    @(negedge clk); a_if.yumi_i = 1'b0; #1;
    check("pulse_r_v_after", 32'(a_if.r_v_o), 0);
    check("pulse_vld", 32'(a_if.valid_pipe_reg_o), 32'h3);
    check("pulse_ready", 32'(a_if.ready_o), 1);

    // A: drain with yumi held
    for (int d = 1; d <= 6; d++) begin
      @(negedge clk);
      a_if.yumi_i = (d <= 5);
      #1;
      check($sformatf("drain_v_o_%0d", d), 32'(a_if.v_o), 32'(d <= 5));
      check($sformatf("drain_r_v_%0d", d), 32'(a_if.r_v_o), 32'(d <= 3));
      if (d <= 3) check($sformatf("drain_raddr_%0d", d), 32'(a_if.r_addr_o), 32'(d - 1));
    end
    a_if.yumi_i = 1'b0;

    // B: bubble collapse, P=3
    @(negedge clk); b_if.v_i = 1'b1; #1;
    check("b1_w_v", 32'(b_if.w_v_o), 1);
    @(negedge clk); b_if.v_i = 1'b0; #1;
    check("b2_r_v", 32'(b_if.r_v_o), 1);
    @(negedge clk); #1;
    check("b3_vld", 32'(b_if.valid_pipe_reg_o), 32'h1);
    check("b3_r_v", 32'(b_if.r_v_o), 0);
    @(negedge clk); #1;
    check("b4_vld", 32'(b_if.valid_pipe_reg_o), 32'h2);
    check("b4_r_v", 32'(b_if.r_v_o), 0);
    @(negedge clk); b_if.yumi_i = 1'b1; #1;
    check("b5_vld", 32'(b_if.valid_pipe_reg_o), 32'h4);
    check("b5_v_o", 32'(b_if.v_o), 1);
    check("b5_r_v", 32'(b_if.r_v_o), 0);
    @(negedge clk); b_if.yumi_i = 1'b0; #1;
    check("b6_vld", 32'(b_if.valid_pipe_reg_o), 0);

    // C: pointer wrap, els_p=3, streaming
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      c_if.v_i    = (k <= 7);
      c_if.yumi_i = (k >= 4 && k <= 10);
      #1;
      check($sformatf("wrap_ready_%0d", k), 32'(c_if.ready_o), 1);
      check($sformatf("wrap_v_o_%0d", k), 32'(c_if.v_o), 32'(k >= 4 && k <= 10));
      check($sformatf("wrap_r_v_%0d", k), 32'(c_if.r_v_o), 32'(k >= 2 && k <= 8));
      if (k <= 7) check($sformatf("wrap_waddr_%0d", k), 32'(c_if.w_addr_o), 32'((k - 1) % 3));
      if (k >= 2 && k <= 8) check($sformatf("wrap_raddr_%0d", k), 32'(c_if.r_addr_o), 32'((k - 2) % 3));
    end
    c_if.yumi_i = 1'b0;

    // C: fill then saturate the 2-bit drop counter
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      c_if.v_i = (k <= 10);
      #1;
      if (k <= 10) check($sformatf("cfill_ready_%0d", k), 32'(c_if.ready_o), 32'(k <= 5));
    end
    check("c_drop_sat", 32'(c_if.drop_count_o), C_DROP);
    check("c_full_vld", 32'(c_if.valid_pipe_reg_o), 32'h3);

    // Asynchronous reset in the middle of a cycle
    @(negedge clk); c_if.v_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_c_vld", 32'(c_if.valid_pipe_reg_o), 0);
    check("arst_c_v_o", 32'(c_if.v_o), 0);
    check("arst_c_ready", 32'(c_if.ready_o), 1);
    check("arst_c_w_v", 32'(c_if.w_v_o), 1);
    check("arst_c_drop", 32'(c_if.drop_count_o), 0);
    check("arst_a_waddr", 32'(a_if.w_addr_o), 0);
    check("arst_a_raddr", 32'(a_if.r_addr_o), 0);
    check("arst_a_ready", 32'(a_if.ready_o), 1);
    c_if.v_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
